// File: rtl/rf_scoreboard.sv
// rf_scoreboard: 8x16 register file with two bypassed read ports, per-register pending-write scoreboard, decode stall, and sticky halt.
module rf_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rs,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rt,
  input  logic                        issue_use_rs,
  input  logic                        issue_use_rt,
  input  logic                        issue_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] issue_wr_reg,
  output logic                        stall,
  output logic [DATA_W-1:0]           read1Data,
  output logic [DATA_W-1:0]           read2Data,
  input  logic                        wb_valid,
  input  logic                        wb_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_wr_reg,
  input  logic [DATA_W-1:0]           writeData,
  input  logic                        wb_halt,
  output logic                        halted,
  output logic                        sb_err
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
  logic              halted_q, halted_d;
  logic              sb_err_q, sb_err_d;
  logic              wb_fire, accept;
  logic [NUM_REGS-1:0] ret, pend, full, inc;

  assign wb_fire   = wb_valid & wb_wr_en & ~halted_q;
  assign read1Data = (wb_fire && wb_wr_reg == issue_rs) ? writeData : regs_q[issue_rs];
  assign read2Data = (wb_fire && wb_wr_reg == issue_rt) ? writeData : regs_q[issue_rt];
  assign stall     = halted_q | (issue_valid & ((issue_use_rs & pend[issue_rs]) |
                                                (issue_use_rt & pend[issue_rt]) |
                                                (issue_wr_en  & full[issue_wr_reg])));
  assign accept    = issue_valid & ~stall;
  assign halted    = halted_q;
  assign sb_err    = sb_err_q;

  // Per-register retire decode and hazard flags; a same-cycle retire releases one pending write.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      ret[i]  = wb_fire && wb_wr_reg == IDX_W'(i);
      pend[i] = cnt_q[i] > CNT_W'(1) || (cnt_q[i] == CNT_W'(1) && !ret[i]);
      full[i] = cnt_q[i] == CNT_MAX && !ret[i];
    end
  end

  // Next state: register writes, counter inc/dec, underflow error and halt capture.
  always_comb begin
    halted_d = halted_q | (wb_valid & wb_halt);
    sb_err_d = sb_err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i]    = accept && issue_wr_en && issue_wr_reg == IDX_W'(i);
      regs_d[i] = ret[i] ? writeData : regs_q[i];
      cnt_d[i]  = (inc[i] && !ret[i]) ? cnt_q[i] + CNT_W'(1) :
                  (ret[i] && !inc[i] && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
      if (ret[i] && !inc[i] && cnt_q[i] == '0) sb_err_d = 1'b1;
    end
  end

  // State registers with asynchronous clear of all in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      halted_q <= 1'b0;
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      halted_q <= halted_d;
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid, issue_use_rs, issue_use_rt, issue_wr_en;
  logic [2:0] issue_rs, issue_rt, issue_wr_reg, wb_wr_reg;
  logic wb_valid, wb_wr_en, wb_halt;
  logic [15:0] writeData, read1Data, read2Data;
  logic stall, halted, sb_err;
  int checks = 0;
  int errors = 0;

  rf_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
    .stall(stall), .read1Data(read1Data), .read2Data(read2Data),
    .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
    .writeData(writeData), .wb_halt(wb_halt),
    .halted(halted), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_wr_en = 0; issue_wr_reg = 0;
    wb_valid = 0; wb_wr_en = 0; wb_wr_reg = 0; writeData = 0; wb_halt = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic iss(input logic [2:0] rs, input logic urs, input logic [2:0] rt, input logic urt,
                     input logic we, input logic [2:0] wr);
    issue_valid = 1; issue_rs = rs; issue_use_rs = urs; issue_rt = rt; issue_use_rt = urt;
    issue_wr_en = we; issue_wr_reg = wr;
  endtask

  task automatic wb(input logic [2:0] r, input logic [15:0] d, input logic h);
    wb_valid = 1; wb_wr_en = 1; wb_wr_reg = r; writeData = d; wb_halt = h;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    // reset state
    nxt(); iss(0, 1, 0, 0, 0, 0); #1;
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_sb_err", {15'd0, sb_err}, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    for (int r = 0; r < 8; r++) begin
      issue_rs = 3'(r); #1;
      chk($sformatf("rst_rd1_r%0d", r), read1Data, 16'h0000);
    end
    // basic write then read
    nxt(); iss(0, 0, 0, 0, 1, 3); #1; chk("wr3_issue_stall", {15'd0, stall}, 16'd0);
    nxt(); wb(3, 16'hBEEF, 0);
    nxt(); iss(3, 1, 0, 0, 0, 0); #1;
    chk("basic_rd1", read1Data, 16'hBEEF);
    chk("basic_stall", {15'd0, stall}, 16'd0);
    chk("basic_sb_err", {15'd0, sb_err}, 16'd0);
    // same-cycle bypass on read port 2
    nxt(); iss(0, 0, 0, 0, 1, 5);
    nxt(); iss(3, 1, 5, 1, 0, 0); wb(5, 16'h1234, 0); #1;
    chk("bypass_rd2", read2Data, 16'h1234);
    chk("bypass_rd1", read1Data, 16'hBEEF);
    chk("bypass_stall", {15'd0, stall}, 16'd0);
    // RAW hazard on r2
    nxt(); iss(0, 0, 0, 0, 1, 2);
    nxt(); iss(2, 1, 0, 0, 0, 0); #1; chk("raw_stall_a", {15'd0, stall}, 16'd1);
    nxt(); iss(2, 1, 0, 0, 0, 0); #1; chk("raw_stall_b", {15'd0, stall}, 16'd1);
    nxt(); iss(2, 1, 0, 0, 0, 0); wb(2, 16'h00AA, 0); #1;
    chk("raw_release_stall", {15'd0, stall}, 16'd0);
    chk("raw_release_rd1", read1Data, 16'h00AA);
    // two writes to r2 in flight
    nxt(); iss(0, 0, 0, 0, 1, 2);
    nxt(); iss(0, 0, 0, 0, 1, 2); #1; chk("raw2_second_issue", {15'd0, stall}, 16'd0);
    nxt(); iss(2, 1, 0, 0, 0, 0); wb(2, 16'h0055, 0); #1;
    chk("raw2_first_ret_stall", {15'd0, stall}, 16'd1);
    chk("raw2_first_ret_rd1", read1Data, 16'h0055);
    nxt(); iss(2, 1, 0, 0, 0, 0); #1;
    chk("raw2_between_stall", {15'd0, stall}, 16'd1);
    chk("raw2_between_rd1", read1Data, 16'h0055);
    nxt(); iss(2, 1, 0, 0, 0, 0); wb(2, 16'h0066, 0); #1;
    chk("raw2_last_ret_stall", {15'd0, stall}, 16'd0);
    chk("raw2_last_ret_rd1", read1Data, 16'h0066);
    // self-dependence: reads own destination without stalling
    nxt(); iss(2, 1, 2, 1, 1, 2); #1; chk("self_dep_stall", {15'd0, stall}, 16'd0);
    nxt(); iss(2, 1, 0, 0, 0, 0); #1; chk("self_dep_follow", {15'd0, stall}, 16'd1);
    nxt(); wb(2, 16'h0077, 0);
    // counter saturation on r7
    for (int k = 0; k < 3; k++) begin
      nxt(); iss(0, 0, 0, 0, 1, 7); #1;
      chk($sformatf("sat_fill_%0d", k), {15'd0, stall}, 16'd0);
    end
    nxt(); iss(0, 0, 0, 0, 1, 7); #1; chk("sat_full_stall", {15'd0, stall}, 16'd1);
    nxt(); iss(0, 0, 0, 0, 1, 7); wb(7, 16'h7777, 0); #1;
    chk("sat_ret_accept", {15'd0, stall}, 16'd0);
    nxt(); iss(0, 0, 0, 0, 1, 7); #1; chk("sat_still_full", {15'd0, stall}, 16'd1);
    for (int k = 0; k < 3; k++) begin
      nxt(); wb(7, 16'h7000 + 16'(k), 0);
    end
    nxt(); iss(7, 1, 0, 0, 0, 0); #1;
    chk("sat_drained_stall", {15'd0, stall}, 16'd0);
    chk("sat_drained_rd1", read1Data, 16'h7002);
    chk("sat_no_err", {15'd0, sb_err}, 16'd0);
    // retire with no pending entry
    nxt(); wb(1, 16'h1111, 0); #1; chk("err_same_cycle", {15'd0, sb_err}, 16'd0);
    nxt(); iss(1, 1, 0, 0, 0, 0); #1;
    chk("err_sticky", {15'd0, sb_err}, 16'd1);
    chk("err_write_done", read1Data, 16'h1111);
    chk("err_cnt_zero_stall", {15'd0, stall}, 16'd0);
    // asynchronous reset with counters nonzero
    nxt(); iss(0, 0, 0, 0, 1, 6);
    nxt(); iss(0, 0, 0, 0, 1, 6);
    nxt(); iss(6, 1, 0, 0, 0, 0); #1; chk("prerst_stall", {15'd0, stall}, 16'd1);
    rst_n = 0; #1;
    chk("async_rst_stall", {15'd0, stall}, 16'd0);
    chk("async_rst_sb_err", {15'd0, sb_err}, 16'd0);
    chk("async_rst_halted", {15'd0, halted}, 16'd0);
    for (int r = 0; r < 8; r++) begin
      issue_rs = 3'(r); #1;
      chk($sformatf("async_rst_rd1_r%0d", r), read1Data, 16'h0000);
    end
    @(negedge clk); rst_n = 1;
    // halt
    nxt(); iss(0, 0, 0, 0, 1, 4);
    nxt(); iss(4, 1, 0, 0, 0, 0); wb(4, 16'h0F0F, 1); #1;
    chk("halt_same_cycle", {15'd0, halted}, 16'd0);
    nxt(); iss(4, 1, 0, 0, 0, 0); #1;
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_stall", {15'd0, stall}, 16'd1);
    chk("halt_rd1", read1Data, 16'h0F0F);
    nxt(); issue_rs = 4; wb(4, 16'hFFFF, 0); #1;
    chk("halt_idle_stall", {15'd0, stall}, 16'd1);
    chk("halt_no_bypass", read1Data, 16'h0F0F);
    nxt(); issue_rs = 4; #1;
    chk("halt_no_write", read1Data, 16'h0F0F);
    chk("halt_sticky", {15'd0, halted}, 16'd1);
    rst_n = 0; #1;
    chk("halt_cleared_by_rst", {15'd0, halted}, 16'd0);
    @(negedge clk); rst_n = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
